// File: rtl/banked_lane_mem_pkg.sv
// Shared types and default sizes for the banked per-lane shader data memory.
package banked_lane_mem_pkg;

    localparam int LANES         = 4;
    localparam int MEM_DEPTH     = 48;
    localparam int DATA_W        = 32;
    localparam int NUM_BANKS_DEF = 4;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [LANES-1:0]  lane_mask_t;

    typedef enum logic [1:0] {IDLE, SERVE, RESP} memfsm_e;

endpackage

// File: rtl/banked_lane_mem_bank.sv
// One single-port memory bank: combinational read, synchronous write, contents not reset.
module banked_lane_mem_bank
    import banked_lane_mem_pkg::*;
#(
    parameter int WORDS = 12,
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  word_t            wdata,
    output word_t            rdata
);

    word_t mem [WORDS];

    assign rdata = mem[row];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[row] <= wdata;
        end
    end

endmodule

// File: rtl/banked_lane_mem.sv
// Warp-wide lane memory over NUM_BANKS single-port banks; same-bank lanes are serialised.
// Optional MEM_BCAST_EN: read lanes sharing the granted lane's address are served together.
module banked_lane_mem
    import banked_lane_mem_pkg::*;
#(
    parameter int DEPTH     = MEM_DEPTH,
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  lane_mask_t                     req_mask,
    input  logic [LANES-1:0][ADDR_W-1:0]   req_addr,
    input  word_t [LANES-1:0]              req_wdata,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output word_t [LANES-1:0]              resp_rdata,
    output lane_mask_t                     resp_oob,
    output logic [CNT_W-1:0]               conflict_cnt
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROWS   = DEPTH / NUM_BANKS;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int LANE_W = $clog2(LANES);

    memfsm_e                          state;
    logic                             lat_we;
    logic [LANES-1:0][ADDR_W-1:0]     lat_addr;
    word_t [LANES-1:0]                lat_wdata;
    lane_mask_t                       pending;
    lane_mask_t                       grant;
    lane_mask_t                       in_range;
    logic                             first_serve;

    logic [NUM_BANKS-1:0]             bank_hit;
    logic [NUM_BANKS-1:0]             bank_we;
    logic [NUM_BANKS-1:0][LANE_W-1:0] bank_lane;
    logic [NUM_BANKS-1:0][ROW_W-1:0]  bank_row;
    word_t [NUM_BANKS-1:0]            bank_wdata;
    word_t [NUM_BANKS-1:0]            bank_rdata;
    word_t [LANES-1:0]                lane_rdata;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            in_range[l] = 32'(req_addr[l]) < 32'(DEPTH);
        end
    end

    // Each bank picks its lowest-index pending lane (scan high to low so the lowest wins).
    always_comb begin
        bank_hit  = '0;
        bank_lane = '0;
        grant     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int l = LANES - 1; l >= 0; l--) begin
                if (pending[l] && lat_addr[l][BANK_W-1:0] == BANK_W'(b)) begin
                    bank_hit[b]  = 1'b1;
                    bank_lane[b] = LANE_W'(l);
                end
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (pending[l] && bank_hit[lat_addr[l][BANK_W-1:0]]) begin
                if (bank_lane[lat_addr[l][BANK_W-1:0]] == LANE_W'(l)) begin
                    grant[l] = 1'b1;
`ifdef MEM_BCAST_EN
                end else if (!lat_we &&
                             lat_addr[l] == lat_addr[bank_lane[lat_addr[l][BANK_W-1:0]]]) begin
                    grant[l] = 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_row[b]   = ROW_W'(lat_addr[bank_lane[b]] >> BANK_W);
            bank_wdata[b] = lat_wdata[bank_lane[b]];
            bank_we[b]    = (state == SERVE) && lat_we && bank_hit[b];
        end
        for (int l = 0; l < LANES; l++) begin
            lane_rdata[l] = bank_rdata[lat_addr[l][BANK_W-1:0]];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        banked_lane_mem_bank #(
            .WORDS (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .row   (bank_row[b]),
            .wdata (bank_wdata[b]),
            .rdata (bank_rdata[b])
        );
    end

    // Request/serve/response sequencing; handshake outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_oob     <= '0;
            conflict_cnt <= '0;
            pending      <= '0;
            first_serve  <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we      <= req_we;
                        lat_addr    <= req_addr;
                        lat_wdata   <= req_wdata;
                        pending     <= req_mask & in_range;
                        resp_oob    <= req_mask & ~in_range;
                        resp_rdata  <= '0;
                        req_ready   <= 1'b0;
                        first_serve <= 1'b1;
                        if ((req_mask & in_range) != '0) begin
                            state <= SERVE;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    pending     <= pending & ~grant;
                    first_serve <= 1'b0;
                    if (!first_serve && conflict_cnt != {CNT_W{1'b1}}) begin
                        conflict_cnt <= conflict_cnt + CNT_W'(1);
                    end
                    for (int l = 0; l < LANES; l++) begin
                        if (grant[l] && !lat_we) begin
                            resp_rdata[l] <= lane_rdata[l];
                        end
                    end
                    if ((pending & ~grant) == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_banked_lane_mem.sv
// Scoreboard bench for banked_lane_mem: a shadow memory predicts read data, OOB flags,
// latency and conflict count for each warp request.
module tb_banked_lane_mem;
    import banked_lane_mem_pkg::*;

    localparam int DEPTH  = MEM_DEPTH;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = 16;
`ifdef MEM_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef struct {
        logic [LANES-1:0][DATA_W-1:0] rdata;
        lane_mask_t                   oob;
        int                           lat;
    } exp_t;

    logic                         clk;
    logic                         rst;
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_we;
    lane_mask_t                   req_mask;
    logic [LANES-1:0][ADDR_W-1:0] req_addr;
    word_t [LANES-1:0]            req_wdata;
    logic                         resp_valid;
    logic                         resp_ready;
    word_t [LANES-1:0]            resp_rdata;
    lane_mask_t                   resp_oob;
    logic [CNT_W-1:0]             conflict_cnt;

    word_t      model_mem [DEPTH];
    logic [CNT_W-1:0] exp_cnt;
    exp_t       sb [$];
    int         errors;
    int         checks;

    banked_lane_mem dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_mask     (req_mask),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_oob     (resp_oob),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES-1:0][ADDR_W-1:0] addr4(input int a0, input int a1,
                                                           input int a2, input int a3);
        return {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    endfunction

    function automatic logic [LANES-1:0][DATA_W-1:0] data4(input int d0, input int d1,
                                                           input int d2, input int d3);
        return {DATA_W'(d3), DATA_W'(d2), DATA_W'(d1), DATA_W'(d0)};
    endfunction

    // Predict the response from the shadow memory, push it, then issue the request.
    task automatic applyStimulus(input logic we, input lane_mask_t mask,
                                 input logic [LANES-1:0][ADDR_W-1:0] addr,
                                 input logic [LANES-1:0][DATA_W-1:0] wdata);
        exp_t e;
        int   serves;
        int   cnt;
        bit   dup;
        e.rdata = '0;
        e.oob   = '0;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l] && addr[l] >= DEPTH) e.oob[l] = 1'b1;
            if (mask[l] && addr[l] < DEPTH && !we) e.rdata[l] = model_mem[addr[l]];
        end
        serves = 0;
        for (int b = 0; b < 4; b++) begin
            cnt = 0;
            for (int l = 0; l < LANES; l++) begin
                if (mask[l] && addr[l] < DEPTH && int'(addr[l][1:0]) == b) begin
                    dup = 1'b0;
                    if (BCAST && !we) begin
                        for (int k = 0; k < l; k++) begin
                            if (mask[k] && addr[k] == addr[l]) dup = 1'b1;
                        end
                    end
                    if (!dup) cnt++;
                end
            end
            if (cnt > serves) serves = cnt;
        end
        if (we) begin
            for (int l = 0; l < LANES; l++) begin
                if (mask[l] && addr[l] < DEPTH) model_mem[addr[l]] = wdata[l];
            end
        end
        e.lat = (serves == 0) ? 1 : serves + 1;
        if (serves > 1) exp_cnt = exp_cnt + CNT_W'(serves - 1);
        sb.push_back(e);
        req_we    = we;
        req_mask  = mask;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("req_ready_busy", 64'(req_ready), 64'(0));
    endtask

    // Wait (bounded) for the response, compare against the scoreboard, optionally stall it.
    task automatic collectResponse(input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (!resp_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        checkOutput("resp_valid", 64'(resp_valid), 64'(1));
        checkOutput("latency", 64'(lat), 64'(e.lat));
        for (int l = 0; l < LANES; l++) begin
            checkOutput($sformatf("rdata%0d", l), 64'(resp_rdata[l]), 64'(e.rdata[l]));
        end
        checkOutput("oob", 64'(resp_oob), 64'(e.oob));
        checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(exp_cnt));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 64'(resp_valid), 64'(1));
            checkOutput("hold_req_ready", 64'(req_ready), 64'(0));
            for (int l = 0; l < LANES; l++) begin
                checkOutput("hold_rdata", 64'(resp_rdata[l]), 64'(e.rdata[l]));
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checkOutput("resp_valid_drop", 64'(resp_valid), 64'(0));
        checkOutput("req_ready_back", 64'(req_ready), 64'(1));
    endtask

    task automatic doTxn(input logic we, input lane_mask_t mask,
                         input logic [LANES-1:0][ADDR_W-1:0] addr,
                         input logic [LANES-1:0][DATA_W-1:0] wdata, input int hold);
        applyStimulus(we, mask, addr, wdata);
        collectResponse(hold);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        checkOutput({tag, "_resp_rdata"}, 64'(resp_rdata[0] | resp_rdata[1] |
                                              resp_rdata[2] | resp_rdata[3]), 64'(0));
        checkOutput({tag, "_resp_oob"}, 64'(resp_oob), 64'(0));
        checkOutput({tag, "_conflict_cnt"}, 64'(conflict_cnt), 64'(0));
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        exp_cnt    = '0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_mask   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < DEPTH / 4; k++) begin
            doTxn(1'b1, 4'hF, addr4(4*k, 4*k+1, 4*k+2, 4*k+3),
                  data4(32'h1000 + 4*k, 32'h1001 + 4*k, 32'h1002 + 4*k, 32'h1003 + 4*k), 0);
        end

        doTxn(1'b1, 4'hF, addr4(0, 1, 2, 3), data4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 0);
        doTxn(1'b0, 4'hF, addr4(0, 1, 2, 3), '0, 0);
        doTxn(1'b0, 4'hF, addr4(0, 4, 8, 12), '0, 0);
        doTxn(1'b1, 4'b1001, addr4(5, 0, 0, 5), data4(32'h11, 0, 0, 32'h33), 0);
        doTxn(1'b0, 4'b0100, addr4(0, 0, 5, 0), '0, 0);
        doTxn(1'b0, 4'b0110, addr4(0, DEPTH, 2, 0), '0, 0);
        doTxn(1'b1, 4'b0001, addr4(DEPTH, 0, 0, 0), data4(32'hDEAD, 0, 0, 0), 0);
        doTxn(1'b0, 4'b0000, addr4(1, 2, 3, 4), '0, 0);
        doTxn(1'b0, 4'hF, addr4(8, 8, 8, 8), '0, 0);
        doTxn(1'b0, 4'hF, addr4(1, 2, 3, 4), '0, 3);

        // Reset after two of four same-bank writes have committed.
        req_we    = 1'b1;
        req_mask  = 4'hF;
        req_addr  = addr4(20, 24, 28, 32);
        req_wdata = data4(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("mid_serve_reset");
        model_mem[20] = 32'hC0;
        model_mem[24] = 32'hC1;
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        doTxn(1'b0, 4'hF, addr4(20, 24, 28, 32), '0, 0);

        for (int n = 0; n < 12; n++) begin
            doTxn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  addr4($urandom_range(0, 51), $urandom_range(0, 51),
                        $urandom_range(0, 51), $urandom_range(0, 51)),
                  data4($urandom, $urandom, $urandom, $urandom), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
